// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, counter width constant/helper, divide-by-zero quotient constant.
package div_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } DivState;

    localparam int DefaultNrOfBits = 32;

    // Iteration counter width for the default operand width.
    localparam int CounterBits = $clog2(DefaultNrOfBits);

    // Quotient returned on divide-by-zero (all ones) at the default width.
    localparam logic [DefaultNrOfBits-1:0] DivZeroQuotient = '1;

    // Counter width for an arbitrary operand width; it must hold NrOfBits-1.
    function automatic int counterWidth(input int nrOfBits);
        return (nrOfBits > 1) ? $clog2(nrOfBits) : 1;
    endfunction

endpackage

// File: rtl/div_sequencer_subtractor.sv
// Subtractor: combinational DataA - DataB - BorrowIn with borrow out.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: DataA/DataB operands, BorrowIn, Result difference, BorrowOut set when DataA < DataB + BorrowIn.
module Subtractor #(
    parameter int NrOfBits     = 8,
    parameter int ExtendedBits = 8
) (
    input  logic [NrOfBits-1:0] DataA,
    input  logic [NrOfBits-1:0] DataB,
    input  logic                BorrowIn,
    output logic [NrOfBits-1:0] Result,
    output logic                BorrowOut
);

    // One extra bit on top catches the wrap-around, which is the borrow.
    logic [NrOfBits:0] wideDiff;

    assign wideDiff  = {1'b0, DataA} - {1'b0, DataB} - {{NrOfBits{1'b0}}, BorrowIn};
    assign Result    = wideDiff[NrOfBits-1:0];
    assign BorrowOut = wideDiff[NrOfBits];

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: restoring divider controller for DIV/DIVU/REM/REMU, one result bit per cycle.
// Latency: Done NrOfBits+3 cycles after the accepting edge; 1 cycle for divide-by-zero.
// Backpressure: Start is accepted only with Busy=0 (IDLE or DONE); ignored otherwise.
// Ports: Clock, ResetN (sync, active low), Start/Signed/IsRem/DataA/DataB request,
//        Busy, Done (1-cycle pulse), Result, DivByZero (held with Result).
// Build option: DIV_SIGNED_EN enables DIV/REM sign handling; undefined gives a DIVU/REMU-only core.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int NrOfBits = DefaultNrOfBits
) (
    input  logic                Clock,
    input  logic                ResetN,
    input  logic                Start,
    input  logic                Signed,
    input  logic                IsRem,
    input  logic [NrOfBits-1:0] DataA,
    input  logic [NrOfBits-1:0] DataB,
    output logic                Busy,
    output logic                Done,
    output logic [NrOfBits-1:0] Result,
    output logic                DivByZero
);

    localparam int CntW = counterWidth(NrOfBits);
    localparam logic [NrOfBits-1:0] DivZeroResult = '1;

    DivState state;
    DivState nextState;

    // quoA starts as the dividend and fills with quotient bits from the lsb.
    logic [NrOfBits-1:0] quoA;
    logic [NrOfBits-1:0] divisor;
    logic [NrOfBits:0]   remReg;
    logic [CntW-1:0]     count;
    logic                isRem;
    logic [NrOfBits-1:0] resultQ;
    logic                divByZeroQ;

    logic [NrOfBits:0]   trial;
    logic [NrOfBits:0]   diff;
    logic                borrow;
    logic                accept;
    logic [NrOfBits-1:0] selected;
    logic [NrOfBits-1:0] fixResult;

    // The remainder never reaches 2^NrOfBits, so its top bit is never consumed.
    logic unusedRemMsb;
    assign unusedRemMsb = remReg[NrOfBits];

`ifdef DIV_SIGNED_EN
    logic isSigned;
    logic negQ;
    logic negR;

    function automatic logic [NrOfBits-1:0] twosNeg(input logic [NrOfBits-1:0] v);
        return ~v + NrOfBits'(1);
    endfunction
`else
    logic unusedSigned;
    assign unusedSigned = Signed;
`endif

    assign accept = Start && ((state == IDLE) || (state == DONE));

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign trial = {remReg[NrOfBits-1:0], quoA[NrOfBits-1]};

    Subtractor #(
        .NrOfBits     (NrOfBits + 1),
        .ExtendedBits (NrOfBits + 1)
    ) subtractorInst (
        .DataA     (trial),
        .DataB     ({1'b0, divisor}),
        .BorrowIn  (1'b0),
        .Result    (diff),
        .BorrowOut (borrow)
    );

    assign selected = isRem ? remReg[NrOfBits-1:0] : quoA;

`ifdef DIV_SIGNED_EN
    assign fixResult = (isRem ? negR : negQ) ? twosNeg(selected) : selected;
`else
    assign fixResult = selected;
`endif

    // State register.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    nextState = (DataB == '0) ? DONE : PREP;
                end else begin
                    nextState = IDLE;
                end
            end
            PREP:    nextState = RUN;
            RUN:     nextState = (count == '0) ? FIX : RUN;
            FIX:     nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs decode the state register only, so no input reaches them combinationally.
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state)
            PREP, RUN, FIX: Busy = 1'b1;
            DONE:           Done = 1'b1;
            default: begin
                Busy = 1'b0;
                Done = 1'b0;
            end
        endcase
    end

    assign Result    = resultQ;
    assign DivByZero = divByZeroQ;

    // Datapath. Result/DivByZero are written only on the edge into DONE.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            quoA       <= '0;
            divisor    <= '0;
            remReg     <= '0;
            count      <= '0;
            isRem      <= 1'b0;
            resultQ    <= '0;
            divByZeroQ <= 1'b0;
`ifdef DIV_SIGNED_EN
            isSigned   <= 1'b0;
            negQ       <= 1'b0;
            negR       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        quoA    <= DataA;
                        divisor <= DataB;
                        isRem   <= IsRem;
`ifdef DIV_SIGNED_EN
                        isSigned <= Signed;
`endif
                        if (DataB == '0) begin
                            resultQ    <= IsRem ? DataA : DivZeroResult;
                            divByZeroQ <= 1'b1;
                        end
                    end
                end
                PREP: begin
`ifdef DIV_SIGNED_EN
                    if (isSigned && quoA[NrOfBits-1]) begin
                        quoA <= twosNeg(quoA);
                    end
                    if (isSigned && divisor[NrOfBits-1]) begin
                        divisor <= twosNeg(divisor);
                    end
                    negQ <= isSigned && (quoA[NrOfBits-1] ^ divisor[NrOfBits-1]);
                    negR <= isSigned && quoA[NrOfBits-1];
`endif
                    remReg <= '0;
                    count  <= CntW'(NrOfBits - 1);
                end
                RUN: begin
                    remReg <= borrow ? trial : diff;
                    quoA   <= {quoA[NrOfBits-2:0], ~borrow};
                    count  <= count - CntW'(1);
                end
                FIX: begin
                    resultQ    <= fixResult;
                    divByZeroQ <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Testbench for div_sequencer: scoreboard of expected results checked on every Done pulse.
// Latency: checks Done timing (NrOfBits+3, or 1 for divide-by-zero) and Busy duration.
// Backpressure: exercises Start while busy, back-to-back Start in the Done cycle and mid-op reset.
module tb_div_sequencer;

    localparam int N = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          ResetN;
    logic          Start;
    logic          Signed;
    logic          IsRem;
    logic [N-1:0]  DataA;
    logic [N-1:0]  DataB;
    logic          Busy;
    logic          Done;
    logic [N-1:0]  Result;
    logic          DivByZero;

    int nTests = 0;
    int nFail  = 0;

    logic [N:0]   expQ[$];
    logic [N:0]   curExp;
    logic [N:0]   monExp;
    logic [N-1:0] prevRes;

    div_sequencer #(.NrOfBits(N)) dut (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .Start     (Start),
        .Signed    (Signed),
        .IsRem     (IsRem),
        .DataA     (DataA),
        .DataB     (DataB),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .DivByZero (DivByZero)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RISC-V division semantics from plain 64-bit arithmetic: {DivByZero, Result}.
    function automatic logic [N:0] refModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input bit sgn, input bit rem);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == '0) begin
            return {1'b1, rem ? a : 32'hFFFF_FFFF};
        end
        if (sgn && SignedEn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, rem ? r[31:0] : q[31:0]};
    endfunction

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clock) begin : monitor
        if (ResetN === 1'b1 && Done === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected_done_queue_depth", 64'(expQ.size()), 64'd1);
            end else begin
                monExp = expQ.pop_front();
                check("result", 64'(Result), 64'(monExp[N-1:0]));
                check("div_by_zero", 64'(DivByZero), 64'(monExp[N]));
            end
        end
    end

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit s, input bit r);
        DataA  = a;
        DataB  = b;
        Signed = s;
        IsRem  = r;
        Start  = 1'b1;
        curExp = refModel(a, b, s, r);
        expQ.push_back(curExp);
    endtask

    // Called at the negedge where Start was raised (cycle 0); returns at the Done negedge.
    task automatic waitDone(input string tag, input int pokeAt);
        int cyc;
        int busyCnt;
        cyc     = 1;
        busyCnt = 0;
        @(negedge Clock);
        Start = 1'b0;
        DataA = $urandom;
        DataB = $urandom;
        while (cyc < 100) begin
            if (Done === 1'b1) break;
            if (Busy === 1'b1) busyCnt++;
            if (cyc == 10) check({tag, "_result_held"}, 64'(Result), 64'(prevRes));
            if (cyc == pokeAt) Start = 1'b1;
            @(negedge Clock);
            Start = 1'b0;
            cyc++;
        end
        check({tag, "_done_cycle"}, 64'(cyc), curExp[N] ? 64'd1 : 64'(N + 3));
        check({tag, "_busy_cycles"}, 64'(busyCnt), curExp[N] ? 64'd0 : 64'(N + 2));
        prevRes = curExp[N-1:0];
    endtask

    initial begin
        ResetN  = 1'b0;
        Start   = 1'b0;
        Signed  = 1'b0;
        IsRem   = 1'b0;
        DataA   = '0;
        DataB   = '0;
        prevRes = '0;
        repeat (3) @(negedge Clock);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_result", 64'(Result), 64'd0);
        check("reset_div_by_zero", 64'(DivByZero), 64'd0);
        ResetN = 1'b1;
        @(negedge Clock);

        // Directed cases; the second one starts in the Done cycle of the first.
        issue(32'd100, 32'd7, 1'b0, 1'b0);          waitDone("u100div7_q", 0);
        issue(32'd100, 32'd7, 1'b0, 1'b1);          waitDone("u100rem7_b2b", 0);
        @(negedge Clock);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);    waitDone("sm7div2_q", 0);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);    waitDone("sm7rem2_r", 0);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);    waitDone("s7divm2_q", 0);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);    waitDone("s7remm2_r", 0);
        @(negedge Clock);
        issue(32'h1234_5678, 32'd0, 1'b0, 1'b0);    waitDone("dz_q", 0);
        @(negedge Clock);
        issue(32'h1234_5678, 32'd0, 1'b1, 1'b1);    waitDone("dz_r", 0);
        @(negedge Clock);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0); waitDone("ovf_q", 0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); waitDone("ovf_r", 0);
        @(negedge Clock);
        issue(32'd1000, 32'd10, 1'b0, 1'b0);        waitDone("start_while_busy", 10);
        @(negedge Clock);

        // Reset in cycle 20 of an operation discards it.
        issue(32'd5000, 32'd3, 1'b0, 1'b0);
        @(negedge Clock);
        Start = 1'b0;
        repeat (19) @(negedge Clock);
        ResetN = 1'b0;
        expQ.delete();
        @(negedge Clock);
        check("midreset_busy", 64'(Busy), 64'd0);
        check("midreset_done", 64'(Done), 64'd0);
        check("midreset_result", 64'(Result), 64'd0);
        check("midreset_div_by_zero", 64'(DivByZero), 64'd0);
        ResetN  = 1'b1;
        prevRes = '0;
        @(negedge Clock);
        issue(32'd9, 32'd3, 1'b0, 1'b0);            waitDone("after_reset", 0);

        // Randomized operations with a mix of corner-case operand classes.
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            int gap;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = N'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: ;
                4: begin a = N'($urandom_range(0, 100)); b = b | 32'h0000_1000; end
                default: b = 32'd1;
            endcase
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge Clock);
            issue(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            waitDone("rand", 0);
        end

        @(negedge Clock);
        @(negedge Clock);
        check("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle restoring divider controller that drives one shared Subtractor instance, one quotient/remainder bit per cycle, to implement DIV/DIVU/REM/REMU for the RV32 core. It sits beside the single-cycle ALU. The core stalls on `Busy` and captures `Result` on the `Done` pulse. All RISC-V corner cases (divide-by-zero, signed overflow) are produced without traps.

## Interface
Parameters:
- `NrOfBits`, 32, operand and result width.

Ports:
- `Clock`, in, 1: single clock; all state changes on the rising edge.
- `ResetN`, in, 1: synchronous, active-low reset.
- `Start`, in, 1: request; accepted when `Busy`=0.
- `Signed`, in, 1: 1 = DIV/REM, 0 = DIVU/REMU; sampled with `Start`.
- `IsRem`, in, 1: 1 = return remainder, 0 = return quotient; sampled with `Start`.
- `DataA`, in, `NrOfBits`: dividend; sampled with `Start`.
- `DataB`, in, `NrOfBits`: divisor; sampled with `Start`.
- `Busy`, out, 1: operation in progress.
- `Done`, out, 1: one-cycle pulse; `Result` valid.
- `Result`, out, `NrOfBits`: quotient or remainder; held until the next accepted `Start`.
- `DivByZero`, out, 1: set with `Done` when `DataB` was 0; held with `Result`.

## Operation
States: IDLE, PREP, RUN, FIX, DONE.
- **IDLE/DONE**, `Start`=1:
  - Latch the operands and flags.
  - `DataB`=0: go to DONE directly.
  - Otherwise go to PREP.
  - `Start` is also accepted in the DONE cycle (back-to-back operation).
- **PREP**:
  - Signed: take the absolute values of A and B.
  - Record `negQ` = sign(A) xor sign(B) and `negR` = sign(A).
  - Clear the partial remainder R (`NrOfBits`+1 bits).
  - Load the iteration counter with `NrOfBits`-1.
- **RUN**, one iteration per cycle:
  - T = {R[`NrOfBits`-1:0], A msb}; shift A left by 1.
  - Subtractor (width `NrOfBits`+1, BorrowIn=0) computes T − {0,B}.
  - BorrowOut=0: R = difference, quotient bit 1.
  - BorrowOut=1: R = T, quotient bit 0.
  - Quotient bits shift into A's vacated lsb.
  - Counter decrements; go to FIX after the iteration at count 0.
- **FIX**:
  - Negate Q if `negQ`; negate R if `negR`.
  - Select the output by `IsRem` and register it into `Result`.
- **DONE**:
  - `Done`=1 for exactly one cycle, then IDLE unless a new `Start` is accepted.
- **Divide-by-zero**:
  - `Result` = all ones (quotient) or A (remainder).
  - `DivByZero`=1, both for signed and unsigned.
- **Signed overflow** (A = −2^(N−1), B = −1):
  - Falls out naturally: quotient = 0x80000000, remainder = 0 (N=32).
  - No special case is needed.
- **`Start` while `Busy`=1**: ignored, with no side effects.
- **`ResetN`=0 in any state**: next state IDLE and all outputs return to reset values; an in-flight operation is discarded.

## Timing
Reset values: `Busy`=0, `Done`=0, `Result`=0, `DivByZero`=0, state IDLE.

Normal operation, with `Start` accepted at the edge ending cycle 0:
- PREP in cycle 1.
- RUN in cycles 2..`NrOfBits`+1.
- FIX in cycle `NrOfBits`+2.
- `Done`=1 in cycle `NrOfBits`+3 (35 for N=32).
- `Busy`=1 in cycles 1..`NrOfBits`+2, and 0 in the `Done` cycle.

Divide-by-zero:
- `Done`=1 in cycle 1.
- `Busy` is never asserted.

`Result` and `DivByZero`:
- Change only on the edge entering DONE, or on reset.
- Stable while `Busy`=1, and hold the previous result.

Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
`DIV_SIGNED_EN`:
- **Defined:** behaviour as above.
- **Undefined:**
  - The `Signed` input is ignored and treated as 0.
  - PREP does no absolute value and FIX does no negation.
  - State sequence and latency are unchanged.
  - The sign logic is removed (DIVU/REMU-only core).

## Structure
- Package `div_sequencer_pkg` holds:
  - the state enum (IDLE, PREP, RUN, FIX, DONE);
  - the counter width constant, $clog2(`NrOfBits`);
  - the divide-by-zero quotient constant (all ones).
- One sub-module: the existing `Subtractor`, instantiated with NrOfBits = ExtendedBits = `NrOfBits`+1. It is the only arithmetic for iterations.
- The PREP/FIX negation uses a separate small two's-complement negator inside this block.

## Test plan
- Unsigned 100 ÷ 7 (`Signed`=0): `IsRem`=0 gives `Result`=14; `IsRem`=1 gives 2. `Done` pulses in cycle 35, with `Busy` high in cycles 1–34.
- Signed −7 ÷ 2: quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Signed 7 ÷ −2 gives quotient −3, remainder 1.
- Divide-by-zero, A = 0x12345678, B = 0: quotient 0xFFFFFFFF and remainder 0x12345678, with `DivByZero`=1. `Done` in cycle 1; `Busy` stays 0.
- Signed 0x80000000 ÷ 0xFFFFFFFF: quotient 0x80000000, remainder 0, `DivByZero`=0.
- `Start` pulsed in cycle 10 of an operation: ignored, result unchanged. `Start` in the `Done` cycle: new operation, next `Done` 35 cycles later.
- `ResetN`=0 in cycle 20 of an operation: the next cycle shows `Busy`=0, `Done`=0, `Result`=0. A subsequent 9 ÷ 3 returns 3.
